// File: rtl/mult_seq_ctrl.sv
// Sequencer for a digit-serial multiplier built around an external DIG_W x DIG_W multiplier.
// Walks every digit pair (i, j) once, steering operand selects, partial-product shift and accumulator control.
module mult_seq_ctrl #(
  parameter  int unsigned OP_W  = 16,
  parameter  int unsigned DIG_W = 4,
  localparam int unsigned NDIG  = OP_W / DIG_W,
  localparam int unsigned SEL_W = $clog2(NDIG),
  localparam int unsigned SH_W  = $clog2(2 * NDIG - 1)
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  input  logic             abort,
  output logic [SEL_W-1:0] a_sel,
  output logic [SEL_W-1:0] b_sel,
  output logic [SH_W-1:0]  shift_sel,
  output logic             clk_ena,
  output logic             sclr_n,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0] DIG_LAST = SEL_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] i_q, i_d;
  logic [SEL_W-1:0] j_q, j_d;

  logic [SEL_W-1:0] a_sel_d, b_sel_d;
  logic [SH_W-1:0]  shift_sel_d;
  logic             clk_ena_d, sclr_n_d, done_d, busy_d, err_d;

  // Next state / counters, then output decode of the upcoming state so outputs stay registered.
  always_comb begin
    state_d     = state_q;
    i_d         = '0;
    j_d         = '0;
    a_sel_d     = '0;
    b_sel_d     = '0;
    shift_sel_d = '0;
    clk_ena_d   = 1'b0;
    sclr_n_d    = 1'b1;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = start ? ST_ERR : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (start) begin
          state_d = ST_ERR;
        end else if ((i_q == DIG_LAST) && (j_q == DIG_LAST)) begin
          state_d = ST_DONE;
        end else if (j_q == DIG_LAST) begin
          i_d = i_q + SEL_W'(1);
          j_d = '0;
        end else begin
          i_d = i_q;
          j_d = j_q + SEL_W'(1);
        end
      end
      ST_DONE: begin
        state_d = start ? ST_CLEAR : ST_IDLE;
      end
      ST_ERR: begin
        state_d = start ? ST_CLEAR : ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      i_d     = '0;
      j_d     = '0;
    end

    case (state_d)
      ST_CLEAR: begin
        sclr_n_d = 1'b0;
        busy_d   = 1'b1;
      end
      ST_ACCUM: begin
        a_sel_d     = i_d;
        b_sel_d     = j_d;
        shift_sel_d = SH_W'(i_d) + SH_W'(j_d);
        clk_ena_d   = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and digit counters.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Output registers track the decode of the state they are loaded alongside.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      a_sel     <= '0;
      b_sel     <= '0;
      shift_sel <= '0;
      clk_ena   <= 1'b0;
      sclr_n    <= 1'b1;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      a_sel     <= a_sel_d;
      b_sel     <= b_sel_d;
      shift_sel <= shift_sel_d;
      clk_ena   <= clk_ena_d;
      sclr_n    <= sclr_n_d;
      done      <= done_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: three parameterisations driven in parallel, checked against a
// step-count reference model plus a hand-written vector table for the default instance.
module tb_mult_seq_ctrl;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_ACCUM = 2;
  localparam int P_DONE  = 3;
  localparam int P_ERR   = 4;

  logic clk;
  logic reset_a;
  logic start;
  logic abort;

  logic [1:0] a0, b0;
  logic [2:0] s0;
  logic [0:0] a1, b1;
  logic [1:0] s1;
  logic [2:0] a2, b2;
  logic [3:0] s2;
  logic [2:0] ena_w, sclr_w, done_w, busy_w, err_w;

  mult_seq_ctrl #(.OP_W(16), .DIG_W(4)) u_dut0 (
    .clk(clk), .reset_a(reset_a), .start(start), .abort(abort),
    .a_sel(a0), .b_sel(b0), .shift_sel(s0),
    .clk_ena(ena_w[0]), .sclr_n(sclr_w[0]), .done(done_w[0]), .busy(busy_w[0]), .err(err_w[0])
  );
  mult_seq_ctrl #(.OP_W(8), .DIG_W(4)) u_dut1 (
    .clk(clk), .reset_a(reset_a), .start(start), .abort(abort),
    .a_sel(a1), .b_sel(b1), .shift_sel(s1),
    .clk_ena(ena_w[1]), .sclr_n(sclr_w[1]), .done(done_w[1]), .busy(busy_w[1]), .err(err_w[1])
  );
  mult_seq_ctrl #(.OP_W(32), .DIG_W(4)) u_dut2 (
    .clk(clk), .reset_a(reset_a), .start(start), .abort(abort),
    .a_sel(a2), .b_sel(b2), .shift_sel(s2),
    .clk_ena(ena_w[2]), .sclr_n(sclr_w[2]), .done(done_w[2]), .busy(busy_w[2]), .err(err_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int a_v[3], b_v[3], s_v[3];
  logic [2:0] x_v;
  always_comb begin
    a_v[0] = int'(a0); b_v[0] = int'(b0); s_v[0] = int'(s0);
    a_v[1] = int'(a1); b_v[1] = int'(b1); s_v[1] = int'(s1);
    a_v[2] = int'(a2); b_v[2] = int'(b2); s_v[2] = int'(s2);
    x_v[0] = $isunknown({a0, b0, s0, ena_w[0], sclr_w[0], done_w[0], busy_w[0], err_w[0]});
    x_v[1] = $isunknown({a1, b1, s1, ena_w[1], sclr_w[1], done_w[1], busy_w[1], err_w[1]});
    x_v[2] = $isunknown({a2, b2, s2, ena_w[2], sclr_w[2], done_w[2], busy_w[2], err_w[2]});
  end

  int errs = 0;
  int nchk = 0;
  int ndig[3];
  int m_ph[3];
  int m_k[3];
  int ena_cnt[3];
  int sh_max[3];

  typedef struct {
    logic st;
    logic ab;
    int   busy;
    int   done;
    int   err;
    int   sclr;
    int   ena;
    int   a;
    int   b;
    int   sh;
  } vec_t;
  vec_t vec[19];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ph[d] = P_IDLE;
      m_k[d]  = 0;
    end
  endtask

  // Operation modelled as a linear step count k over NDIG*NDIG digit pairs.
  task automatic model_step(input logic st, input logic ab);
    for (int d = 0; d < 3; d++) begin
      if (reset_a) begin
        m_ph[d] = P_IDLE; m_k[d] = 0;
      end else if (ab) begin
        m_ph[d] = P_IDLE; m_k[d] = 0;
      end else begin
        case (m_ph[d])
          P_IDLE:  if (st) m_ph[d] = P_CLEAR;
          P_CLEAR: begin m_ph[d] = st ? P_ERR : P_ACCUM; m_k[d] = 0; end
          P_ACCUM: begin
            if (st) begin m_ph[d] = P_ERR; m_k[d] = 0; end
            else if (m_k[d] == ndig[d] * ndig[d] - 1) begin m_ph[d] = P_DONE; m_k[d] = 0; end
            else m_k[d] = m_k[d] + 1;
          end
          P_DONE:  m_ph[d] = st ? P_CLEAR : P_IDLE;
          default: m_ph[d] = st ? P_CLEAR : P_ERR;
        endcase
      end
    end
  endtask

  task automatic check_all();
    int ea, eb;
    for (int d = 0; d < 3; d++) begin
      ea = (m_ph[d] == P_ACCUM) ? m_k[d] / ndig[d] : 0;
      eb = (m_ph[d] == P_ACCUM) ? m_k[d] % ndig[d] : 0;
      chk("no_x",      d, int'(x_v[d]), 0);
      chk("a_sel",     d, a_v[d], ea);
      chk("b_sel",     d, b_v[d], eb);
      chk("shift_sel", d, s_v[d], ea + eb);
      chk("clk_ena",   d, int'(ena_w[d]),  (m_ph[d] == P_ACCUM) ? 1 : 0);
      chk("sclr_n",    d, int'(sclr_w[d]), (m_ph[d] == P_CLEAR) ? 0 : 1);
      chk("done",      d, int'(done_w[d]), (m_ph[d] == P_DONE) ? 1 : 0);
      chk("busy",      d, int'(busy_w[d]), (m_ph[d] == P_CLEAR || m_ph[d] == P_ACCUM) ? 1 : 0);
      chk("err",       d, int'(err_w[d]),  (m_ph[d] == P_ERR) ? 1 : 0);
      if (ena_w[d]) ena_cnt[d]++;
      if (s_v[d] > sh_max[d]) sh_max[d] = s_v[d];
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int d = 0; d < 3; d++) begin
      chk({nm, "_sel"}, d, a_v[d] + b_v[d] + s_v[d], 0);
      chk({nm, "_ena"}, d, int'(ena_w[d]), 0);
      chk({nm, "_sclr"}, d, int'(sclr_w[d]), 1);
      chk({nm, "_flags"}, d, int'({done_w[d], busy_w[d], err_w[d]}), 0);
    end
  endtask

  task automatic cycle(input logic st, input logic ab);
    @(negedge clk);
    start = st;
    abort = ab;
    @(posedge clk);
    model_step(st, ab);
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 1'b0);
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic async_reset();
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #2;
    reset_a = 1'b1;
    #1;
    model_reset();
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    reset_a = 1'b0;
  endtask

  initial begin
    ndig[0] = 4; ndig[1] = 2; ndig[2] = 8;
    for (int d = 0; d < 3; d++) begin ena_cnt[d] = 0; sh_max[d] = 0; end

    vec[0]  = '{1'b1, 1'b0, 1, 0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 0, 0, 0};
    vec[2]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 0, 1, 1};
    vec[3]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 0, 2, 2};
    vec[4]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 0, 3, 3};
    vec[5]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 1, 0, 1};
    vec[6]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 1, 1, 2};
    vec[7]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 1, 2, 3};
    vec[8]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 1, 3, 4};
    vec[9]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 2, 0, 2};
    vec[10] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 2, 1, 3};
    vec[11] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 2, 2, 4};
    vec[12] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 2, 3, 5};
    vec[13] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 3, 0, 3};
    vec[14] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 3, 1, 4};
    vec[15] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 3, 2, 5};
    vec[16] = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 3, 3, 6};
    vec[17] = '{1'b0, 1'b0, 0, 1, 0, 1, 0, 0, 0, 0};
    vec[18] = '{1'b0, 1'b0, 0, 0, 0, 1, 0, 0, 0, 0};

    reset_a = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset_a = 1'b0;

    // Nominal run on the default instance, start sampled at the first edge out of reset.
    for (int v = 0; v < 19; v++) begin
      cycle(vec[v].st, vec[v].ab);
      chk("tbl_busy", v, int'(busy_w[0]), vec[v].busy);
      chk("tbl_done", v, int'(done_w[0]), vec[v].done);
      chk("tbl_err",  v, int'(err_w[0]),  vec[v].err);
      chk("tbl_sclr", v, int'(sclr_w[0]), vec[v].sclr);
      chk("tbl_ena",  v, int'(ena_w[0]),  vec[v].ena);
      chk("tbl_a",    v, int'(a0), vec[v].a);
      chk("tbl_b",    v, int'(b0), vec[v].b);
      chk("tbl_sh",   v, int'(s0), vec[v].sh);
    end
    idle_cycles(70);

    // Back-to-back: start during DONE goes straight to CLEAR.
    cycle(1'b1, 1'b0);
    idle_cycles(17);
    chk("b2b_done1", 0, int'(done_w[0]), 1);
    cycle(1'b1, 1'b0);
    chk("b2b_clear", 0, int'(sclr_w[0]), 0);
    idle_cycles(17);
    chk("b2b_done2", 0, int'(done_w[0]), 1);
    idle_cycles(70);

    // Violation at the 5th ACCUM cycle, then recovery from ERR.
    cycle(1'b1, 1'b0);
    idle_cycles(5);
    chk("viol_k", 0, int'(a0) * 4 + int'(b0), 4);
    cycle(1'b1, 1'b0);
    chk("viol_err", 0, int'(err_w[0]), 1);
    chk("viol_ena", 0, int'(ena_w[0]), 0);
    idle_cycles(3);
    chk("err_hold", 0, int'(err_w[0]), 1);
    cycle(1'b1, 1'b0);
    idle_cycles(17);
    chk("recov_done", 0, int'(done_w[0]), 1);
    idle_cycles(70);

    // Abort with start at the 8th ACCUM cycle; abort wins.
    cycle(1'b1, 1'b0);
    idle_cycles(8);
    chk("abort_k", 0, int'(a0) * 4 + int'(b0), 7);
    cycle(1'b1, 1'b1);
    chk("abort_idle", 0, int'({busy_w[0], err_w[0]}), 0);
    idle_cycles(20);

    // Asynchronous reset mid-ACCUM.
    cycle(1'b1, 1'b0);
    idle_cycles(6);
    async_reset();
    idle_cycles(20);

    // Full-length run on every instance for the parameter sweep.
    for (int d = 0; d < 3; d++) begin ena_cnt[d] = 0; sh_max[d] = 0; end
    cycle(1'b1, 1'b0);
    idle_cycles(70);
    chk("sweep_len", 0, ena_cnt[0], 16);
    chk("sweep_len", 1, ena_cnt[1], 4);
    chk("sweep_len", 2, ena_cnt[2], 64);
    chk("sweep_shmax", 0, sh_max[0], 6);
    chk("sweep_shmax", 1, sh_max[1], 2);
    chk("sweep_shmax", 2, sh_max[2], 14);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) async_reset();
      else cycle(($urandom_range(7) == 0), ($urandom_range(31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter OP_W, default 16: operand width in bits; SHALL be an integer multiple of DIG_W.
REQ-002 Parameter DIG_W, default 4: digit width in bits, matching the external DIG_W x DIG_W multiplier.
REQ-003 Derived values SHALL be fixed as follows:
- NDIG = OP_W/DIG_W, a power of 2 and at least 2.
- SEL_W = clog2(NDIG).
- SH_W = clog2(2*NDIG-1).
REQ-004 Port clk, input, width 1: single clock; all state changes on its rising edge.
REQ-005 Port reset_a, input, width 1: asynchronous, active-high reset.
REQ-006 Port start, input, width 1: request to begin a multiply.
REQ-007 Port abort, input, width 1: cancel the current operation and return to IDLE.
REQ-008 Port a_sel, output, width SEL_W: index of the operand-A digit routed to the multiplier.
REQ-009 Port b_sel, output, width SEL_W: index of the operand-B digit routed to the multiplier.
REQ-010 Port shift_sel, output, width SH_W: left shift of the partial product, in digits.
REQ-011 Port clk_ena, output, width 1: accumulator load enable.
REQ-012 Port sclr_n, output, width 1: active-low synchronous clear of the accumulator.
REQ-013 Port done, output, width 1: result valid, one-cycle pulse.
REQ-014 Port busy, output, width 1: high in the CLEAR and ACCUM states.
REQ-015 Port err, output, width 1: protocol-violation flag, level signal.

Function
REQ-016 FSM states SHALL be exactly IDLE, CLEAR, ACCUM, DONE and ERR; unused encodings SHALL go to ERR.
REQ-017 All outputs SHALL be Moore: decoded only from the registered state and the digit counters i and j, with no combinational path from any input.
REQ-018 In IDLE: start=1 -> CLEAR; otherwise stay in IDLE.
REQ-019 In CLEAR (one cycle): sclr_n=0, clk_ena=0; next state ACCUM with i=0, j=0.
REQ-020 In ACCUM, each cycle SHALL drive:
- a_sel=i, b_sel=j;
- shift_sel=i+j, zero-extended to SH_W with no overflow;
- clk_ena=1.
REQ-021 In ACCUM, the counters SHALL advance as follows:
- j increments every cycle;
- when j=NDIG-1, j wraps to 0 and i increments.
REQ-022 At i=j=NDIG-1 the next state SHALL be DONE, so ACCUM lasts exactly NDIG*NDIG cycles.
REQ-023 In DONE (one cycle): done=1, clk_ena=0; start=1 -> CLEAR (back-to-back operation); otherwise -> IDLE.
REQ-024 start=1 during ACCUM or CLEAR is a violation and SHALL cause the following:
- next state ERR;
- counters cleared;
- the clk_ena of the current cycle is unaffected.
REQ-025 In ERR: err=1, clk_ena=0; start=1 -> CLEAR; otherwise stay in ERR.
REQ-026 abort=1 in any state SHALL force the next state to IDLE and clear the counters; abort SHALL have priority over start.
REQ-027 Outside ACCUM, a_sel, b_sel and shift_sel SHALL be 0; they SHALL never be X.
REQ-028 Outside CLEAR, sclr_n SHALL be 1.
REQ-029 Latency: with start sampled high in IDLE at edge T, done SHALL be high in cycle T+2+NDIG*NDIG (T+18 at default parameters).

Reset
REQ-030 While reset_a=1 the block SHALL hold the following, asynchronously and independent of clk:
- state=IDLE;
- i=0, j=0;
- a_sel=0, b_sel=0, shift_sel=0;
- clk_ena=0, done=0, busy=0, err=0;
- sclr_n=1.
REQ-031 Reset asserted mid-ACCUM SHALL abandon the operation; after release, no done pulse SHALL occur until a new start.
REQ-032 The first start SHALL be sampled at the first rising clk edge with reset_a=0.

Verification
REQ-033 Nominal run (defaults): 1-cycle start pulse in IDLE. Required response:
- 1 CLEAR cycle with sclr_n=0;
- 16 ACCUM cycles with (a_sel,b_sel,shift_sel) = (0,0,0),(0,1,1)...(0,3,3),(1,0,1)...(3,3,6);
- done=1 exactly once, then IDLE.
REQ-034 Back-to-back: start=1 in the DONE cycle -> CLEAR on the next cycle, then a second full 16-cycle sequence with no IDLE cycle in between.
REQ-035 Violation: start=1 at the 5th ACCUM cycle -> err=1 from the next cycle, clk_ena=0, selects=0, no done; then start=1 -> CLEAR and a clean run.
REQ-036 Abort: abort=1 together with start=1 at the 8th ACCUM cycle -> IDLE on the next cycle, err=0, done never pulses.
REQ-037 Reset: reset_a asserted mid-ACCUM (asynchronously, between clock edges) -> all outputs at their reset values immediately; after release, idle with no done.
REQ-038 Parameter sweep: OP_W=8, DIG_W=4 -> 4 ACCUM cycles, shift_sel max 2, done at T+6; OP_W=32, DIG_W=4 -> 64 ACCUM cycles, shift_sel max 14.
